io_handshake_unit: RTL and testbench

IO_HANDSHAKE_UNIT -- requirements
Module: io_handshake_unit

---
 rtl/io_handshake_unit_pkg.sv | 23 ++
 rtl/io_handshake_unit_button_debouncer.sv | 54 +++++
 rtl/io_handshake_unit.sv | 89 ++++++++
 tb/tb_io_handshake_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the I/O handshake unit and the control decoder:
// FSM state encoding and IO_Selection operation codes.
package io_handshake_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_DONE         = 2'd3
    } io_state_e;

    typedef enum logic [1:0] {
        IO_OUT  = 2'd0,
        IO_IN   = 2'd1,
        IO_GETC = 2'd2,
        IO_RSVD = 2'd3
    } io_sel_e;

    function automatic logic is_in_request(input logic enable, input logic [1:0] selection);
        return enable && (selection == IO_IN);
    endfunction

endpackage

// File: rtl/io_handshake_unit_button_debouncer.sv
// Two-flop synchronizer plus debounce filter for the confirm button; emits
// one-cycle pulses when a new press or release level is accepted.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized level matches the accepted level restarts the count.
    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        level_d       = level_q;
        cnt_d         = '0;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d       = sync2_q;
                press_pulse   = sync2_q;
                release_pulse = !sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/io_handshake_unit.sv
// I/O handshake unit: OUT latches a display register, GETC returns the context
// number, IN stalls the pipeline until a debounced press/release of Enter_Btn.
module io_handshake_unit
    import io_handshake_unit_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IO_Enable,
    input  logic [1:0]        IO_Selection,
    input  logic [DATA_W-1:0] Reg_Data,
    input  logic [7:0]        Context_ID,
    input  logic [SW_W-1:0]   Switch_Data,
    input  logic              Enter_Btn,
    output logic [DATA_W-1:0] IO_Result,
    output logic [DATA_W-1:0] Out_Display,
    output logic              Stall
);

    io_state_e         state_q, state_d;
    logic [DATA_W-1:0] in_reg_q, in_reg_d;
    logic [DATA_W-1:0] out_display_q, out_display_d;
    logic              press_pulse, release_pulse;
    logic              in_request;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (Clock),
        .rst          (Reset),
        .btn_raw      (Enter_Btn),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    assign in_request = is_in_request(IO_Enable, IO_Selection);

    // Once an IN starts it runs to completion even if IO_Enable drops.
    always_comb begin
        state_d       = state_q;
        in_reg_d      = in_reg_q;
        out_display_d = out_display_q;
        case (state_q)
            ST_IDLE: begin
                if (in_request) state_d = ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                if (press_pulse) begin
                    in_reg_d = DATA_W'(Switch_Data);
                    state_d  = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (release_pulse) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (IO_Enable && (IO_Selection == IO_OUT)) out_display_d = Reg_Data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            in_reg_q      <= '0;
            out_display_q <= '0;
        end else begin
            state_q       <= state_d;
            in_reg_q      <= in_reg_d;
            out_display_q <= out_display_d;
        end
    end

    always_comb begin
        case (IO_Selection)
            IO_IN:   IO_Result = in_reg_q;
            IO_GETC: IO_Result = DATA_W'(Context_ID);
            default: IO_Result = '0;
        endcase
    end

    assign Stall = !Reset && ((state_q == ST_IDLE && in_request) ||
                              state_q == ST_WAIT_PRESS || state_q == ST_WAIT_RELEASE);
    assign Out_Display = out_display_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for io_handshake_unit: constant vector table, hand-written IN/bounce/
// pre-held/reset sequences, and random traffic against a cycle-level model.
module tb_io_handshake_unit;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst, en, btn;
    logic [1:0]  sel;
    logic [31:0] reg_data;
    logic [7:0]  ctx;
    logic [15:0] sw;
    logic [31:0] io_result, out_display;
    logic        stall;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 awaiting press, 2 awaiting release, 3 done.
    int          m_mode = 0;
    bit          m_s1 = 0, m_s2 = 0, m_acc = 0;
    int          m_run = 0;
    logic [31:0] m_in = 0, m_out = 0;

    logic        s_stall;
    logic [31:0] s_result, s_out;

    typedef struct {
        bit        rst;
        bit        en;
        bit [1:0]  sel;
        bit [31:0] rd;
        bit [7:0]  ctx;
        bit [15:0] sw;
        bit        btn;
        bit        xs;
        bit [31:0] xr;
        bit [31:0] xo;
    } vec_t;

    vec_t vecs[7];

    io_handshake_unit #(
        .DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .Clock(clk), .Reset(rst), .IO_Enable(en), .IO_Selection(sel),
        .Reg_Data(reg_data), .Context_ID(ctx), .Switch_Data(sw),
        .Enter_Btn(btn), .IO_Result(io_result), .Out_Display(out_display),
        .Stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the falling edge, compare with the model, advance at the rising edge.
    task automatic apply_stimulus(input bit r, input bit e, input bit [1:0] s, input bit [31:0] rd,
                                  input bit [7:0] c, input bit [15:0] w, input bit b);
        bit          exp_stall;
        logic [31:0] exp_res;
        bit          synced_press, synced_release;
        @(negedge clk);
        rst = r; en = e; sel = s; reg_data = rd; ctx = c; sw = w; btn = b;
        #1;
        s_stall = stall; s_result = io_result; s_out = out_display;
        exp_stall = !r && ((m_mode == 0 && e && s == 2'd1) || m_mode == 1 || m_mode == 2);
        exp_res   = (s == 2'd1) ? m_in : (s == 2'd2) ? {24'd0, c} : 32'd0;
        check_output("model_stall", {31'd0, s_stall}, {31'd0, exp_stall});
        check_output("model_result", s_result, exp_res);
        check_output("model_out", s_out, m_out);
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_in = 0; m_out = 0;
        end else begin
            synced_press = 0; synced_release = 0;
            if (m_s2 != m_acc) begin
                m_run++;
                if (m_run == DC) begin
                    synced_press = m_s2; synced_release = !m_s2; m_acc = m_s2; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            case (m_mode)
                0: if (e && s == 2'd1) m_mode = 1;
                1: if (synced_press) begin m_in = {16'd0, w}; m_mode = 2; end
                2: if (synced_release) m_mode = 3;
                default: m_mode = 0;
            endcase
            if (e && s == 2'd0) m_out = rd;
            m_s2 = m_s1; m_s1 = b;
        end
    endtask

    task automatic finish_in(input bit [15:0] w, input string name, output int cycles);
        cycles = -1;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(0, 0, 2'd1, 0, 0, w, 0);
            if (!s_stall) begin cycles = i; break; end
        end
        check_output({name, "_done_seen"}, {31'd0, cycles >= 0}, 32'd1);
    endtask

    initial begin
        int done_at;
        int hold;
        bit rb;

        vecs[0] = '{1, 0, 2'd0, 32'h0,  8'h0, 16'h0, 0, 0, 32'h0, 32'h0};
        vecs[1] = '{0, 1, 2'd0, 32'hA5, 8'h0, 16'h0, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{0, 0, 2'd0, 32'h0,  8'h0, 16'h0, 0, 0, 32'h0, 32'hA5};
        vecs[3] = '{0, 1, 2'd2, 32'h0,  8'h3, 16'h0, 0, 0, 32'h3, 32'hA5};
        vecs[4] = '{0, 1, 2'd3, 32'hFF, 8'h7, 16'h9, 0, 0, 32'h0, 32'hA5};
        vecs[5] = '{0, 0, 2'd3, 32'h0,  8'h0, 16'h0, 0, 0, 32'h0, 32'hA5};
        vecs[6] = '{0, 0, 2'd1, 32'h0,  8'h0, 16'h0, 0, 0, 32'h0, 32'hA5};

        rst = 1; en = 0; sel = 0; reg_data = 0; ctx = 0; sw = 0; btn = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].rd,
                           vecs[i].ctx, vecs[i].sw, vecs[i].btn);
            check_output($sformatf("vec%0d_stall", i), {31'd0, s_stall}, {31'd0, vecs[i].xs});
            check_output($sformatf("vec%0d_result", i), s_result, vecs[i].xr);
            check_output($sformatf("vec%0d_out", i), s_out, vecs[i].xo);
        end

        // Clean IN: press held 6 cycles, then release; DONE expected 6 cycles into release.
        apply_stimulus(0, 1, 2'd1, 0, 0, 16'h1234, 0);
        check_output("in_issue_stall", {31'd0, s_stall}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 2'd1, 0, 0, 16'h1234, 1);
            check_output("in_press_stall", {31'd0, s_stall}, 32'd1);
        end
        finish_in(16'h1234, "in", done_at);
        check_output("in_done_latency", done_at, 32'd6);
        check_output("in_done_result", s_result, 32'h0000_1234);
        apply_stimulus(0, 1, 2'd1, 0, 0, 16'h00CC, 0);
        check_output("in_idle_after_done", {31'd0, s_stall}, 32'd1);

        // Reset while waiting for release.
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 2'd1, 0, 0, 16'h00CC, 1);
        check_output("rst_pre_capture", s_result, 32'h0000_00CC);
        apply_stimulus(1, 0, 2'd1, 0, 0, 16'h00CC, 1);
        check_output("rst_stall_drop", {31'd0, s_stall}, 32'd0);
        apply_stimulus(0, 0, 2'd1, 0, 0, 16'h00CC, 0);
        check_output("rst_stall_after", {31'd0, s_stall}, 32'd0);
        check_output("rst_out_cleared", s_out, 32'd0);
        check_output("rst_inreg_cleared", s_result, 32'd0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 2'd0, 0, 0, 0, 0);

        // Bounce 1,0,1,0 then hold: capture visible only 6 cycles into the hold.
        apply_stimulus(0, 1, 2'd1, 0, 0, 16'h0777, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 2'd1, 0, 0, 16'h0777, (i % 2) == 0);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(0, 0, 2'd1, 0, 0, 16'h0777, 1);
            check_output($sformatf("bounce_hold%0d", k), s_result, (k >= 6) ? 32'h777 : 32'h0);
        end
        finish_in(16'h0777, "bounce", done_at);
        check_output("bounce_result", s_result, 32'h0000_0777);

        // Pre-held button must be released and pressed again.
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 2'd0, 0, 0, 0, 1);
        apply_stimulus(0, 1, 2'd1, 0, 0, 16'h0BAD, 1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 2'd1, 0, 0, 16'h0BAD, 1);
            check_output("held_stall", {31'd0, s_stall}, 32'd1);
        end
        for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 2'd1, 0, 0, 16'h0BAD, 0);
        check_output("held_no_capture", s_result, 32'h0000_0777);
        for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 2'd1, 0, 0, 16'h5A5A, 1);
        finish_in(16'hFFFF, "held", done_at);
        check_output("held_result", s_result, 32'h0000_5A5A);

        // Random traffic; button levels held for random run lengths.
        hold = 0; rb = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                rb = $urandom_range(0, 1);
                hold = $urandom_range(1, 7);
            end
            hold--;
            apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1),
                           2'($urandom_range(0, 3)), $urandom, 8'($urandom),
                           16'($urandom), rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
